// File: rtl/vdp_reg_write_arbiter_pkg.sv
// Shared definitions for the VDP register write arbiter: bus widths,
// grant source encodings, host slot states and the copper FIFO entry layout.
package vdp_reg_write_arbiter_pkg;

  localparam int VDP_REG_ADDR_W = 5;
  localparam int VDP_REG_DATA_W = 16;
  localparam int COP_ENTRY_W    = VDP_REG_ADDR_W + VDP_REG_DATA_W;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_HOST = 2'd1,
    SRC_COP  = 2'd2
  } grant_src_e;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_PEND = 1'b1
  } host_state_e;

  typedef struct packed {
    logic [VDP_REG_ADDR_W-1:0] address;
    logic [VDP_REG_DATA_W-1:0] data;
  } reg_write_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/vdp_cop_write_fifo.sv
// Copper write FIFO: first-word-fall-through synchronous FIFO whose entries
// pack a register address and data word; occupancy is tracked explicitly.
module vdp_cop_write_fifo
  import vdp_reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [COP_ENTRY_W-1:0] push_entry,
  input  logic                   pop,
  output logic [COP_ENTRY_W-1:0] pop_entry,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic [COP_ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign pop_entry = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// Arbitrates the single VDP register write port between a one-slot CPU host
// buffer and the copper FIFO, with a starvation guard and downstream stall.
module vdp_reg_write_arbiter
  import vdp_reg_write_arbiter_pkg::*;
#(
  parameter int COP_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            host_write_en,
  input  logic [VDP_REG_ADDR_W-1:0]       host_address,
  input  logic [VDP_REG_DATA_W-1:0]       host_write_data,
  output logic                            host_ready,
  input  logic                            cop_write_valid,
  input  logic [VDP_REG_ADDR_W-1:0]       cop_write_address,
  input  logic [VDP_REG_DATA_W-1:0]       cop_write_data,
  output logic                            cop_write_ready,
  input  logic                            port_stall,
  output logic                            register_write_en,
  output logic [VDP_REG_ADDR_W-1:0]       register_write_address,
  output logic [VDP_REG_DATA_W-1:0]       register_write_data,
  output logic [$clog2(COP_FIFO_DEPTH):0] cop_fifo_level,
  output logic [7:0]                      conflict_count,
  output logic                            protocol_error
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]                rst_sync;
  logic                      rst_n;
  host_state_e               host_state;
  host_state_e               host_state_next;
  logic                      host_en_q;
  logic                      host_edge;
  logic                      host_pending;
  logic                      host_accept;
  logic                      host_violation;
  logic [VDP_REG_ADDR_W-1:0] slot_address;
  logic [VDP_REG_DATA_W-1:0] slot_data;
  logic [COP_ENTRY_W-1:0]    fifo_push_entry;
  logic [COP_ENTRY_W-1:0]    fifo_pop_entry;
  reg_write_t                cop_in;
  reg_write_t                cop_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      cop_pending;
  logic                      both_pending;
  grant_src_e                grant_src;
  logic [3:0]                starve_cnt;

  // Reset asserts asynchronously but releases only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign host_edge = host_write_en && !host_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_state <= H_IDLE;
    else        host_state <= host_state_next;
  end

  always_comb begin
    host_state_next = host_state;
    case (host_state)
      H_IDLE:  if (host_edge) host_state_next = H_PEND;
      H_PEND:  if (grant_src == SRC_HOST) host_state_next = H_IDLE;
      default: host_state_next = H_IDLE;
    endcase
  end

  always_comb begin
    host_pending   = (host_state == H_PEND);
    host_accept    = host_edge && (host_state == H_IDLE);
    host_violation = host_edge && (host_state == H_PEND);
  end

  // The slot captures address/data only on an accepted edge; a second edge
  // while the slot is full is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_en_q      <= 1'b0;
      slot_address   <= '0;
      slot_data      <= '0;
      protocol_error <= 1'b0;
    end else begin
      host_en_q <= host_write_en;
      if (host_accept) begin
        slot_address <= host_address;
        slot_data    <= host_write_data;
      end
      if (host_violation) protocol_error <= 1'b1;
    end
  end

  assign cop_in.address  = cop_write_address;
  assign cop_in.data     = cop_write_data;
  assign fifo_push_entry = cop_in;
  assign cop_head        = reg_write_t'(fifo_pop_entry);
  assign cop_write_ready = !fifo_full;
  assign cop_pending     = !fifo_empty;
  assign both_pending    = host_pending && cop_pending;

  vdp_cop_write_fifo #(
    .DEPTH (COP_FIFO_DEPTH)
  ) u_cop_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (cop_write_valid && cop_write_ready),
    .push_entry (fifo_push_entry),
    .pop        (grant_src == SRC_COP),
    .pop_entry  (fifo_pop_entry),
    .level      (cop_fifo_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    grant_src = SRC_NONE;
    if (!port_stall) begin
      if (both_pending)      grant_src = (starve_cnt == STARVE_MAX) ? SRC_COP : SRC_HOST;
      else if (host_pending) grant_src = SRC_HOST;
      else if (cop_pending)  grant_src = SRC_COP;
    end
  end

  // Counts host wins over a waiting copper; frozen while the port is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt     <= '0;
      conflict_count <= '0;
    end else begin
      if (!port_stall) begin
        if (grant_src == SRC_COP || fifo_empty) starve_cnt <= '0;
        else if (grant_src == SRC_HOST)         starve_cnt <= starve_cnt + 4'd1;
      end
      if (grant_src != SRC_NONE && both_pending) conflict_count <= sat_inc8(conflict_count);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      register_write_en      <= 1'b0;
      register_write_address <= '0;
      register_write_data    <= '0;
      host_ready             <= 1'b0;
    end else begin
      register_write_en <= (grant_src != SRC_NONE);
      host_ready        <= (grant_src == SRC_HOST);
      if (grant_src == SRC_HOST) begin
        register_write_address <= slot_address;
        register_write_data    <= slot_data;
      end else if (grant_src == SRC_COP) begin
        register_write_address <= cop_head.address;
        register_write_data    <= cop_head.data;
      end
    end
  end

endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// Scoreboard bench for vdp_reg_write_arbiter: directed sequences push the
// expected register writes; a negedge monitor pops and compares them.
module tb_vdp_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_write_en;
  logic [4:0]  host_address;
  logic [15:0] host_write_data;
  logic        host_ready;
  logic        cop_write_valid;
  logic [4:0]  cop_write_address;
  logic [15:0] cop_write_data;
  logic        cop_write_ready;
  logic        port_stall;
  logic        register_write_en;
  logic [4:0]  register_write_address;
  logic [15:0] register_write_data;
  logic [2:0]  cop_fifo_level;
  logic [7:0]  conflict_count;
  logic        protocol_error;

  typedef struct {
    bit          host;
    logic [4:0]  addr;
    logic [15:0] data;
    int          at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vdp_reg_write_arbiter #(
    .COP_FIFO_DEPTH (4),
    .STARVE_LIMIT   (3)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .host_write_en          (host_write_en),
    .host_address           (host_address),
    .host_write_data        (host_write_data),
    .host_ready             (host_ready),
    .cop_write_valid        (cop_write_valid),
    .cop_write_address      (cop_write_address),
    .cop_write_data         (cop_write_data),
    .cop_write_ready        (cop_write_ready),
    .port_stall             (port_stall),
    .register_write_en      (register_write_en),
    .register_write_address (register_write_address),
    .register_write_data    (register_write_data),
    .cop_fifo_level         (cop_fifo_level),
    .conflict_count         (conflict_count),
    .protocol_error         (protocol_error)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic applyStimulus(input logic h_en, input logic [4:0] h_addr, input logic [15:0] h_data,
                               input logic c_valid, input logic [4:0] c_addr, input logic [15:0] c_data,
                               input logic stall);
    host_write_en     = h_en;
    host_address      = h_addr;
    host_write_data   = h_data;
    cop_write_valid   = c_valid;
    cop_write_address = c_addr;
    cop_write_data    = c_data;
    port_stall        = stall;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input bit host, input logic [4:0] addr, input logic [15:0] data, input int at_cyc);
    exp_t e;
    e.host   = host;
    e.addr   = addr;
    e.data   = data;
    e.at_cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  // Every issued register write must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (register_write_en) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h host_ready %0b, expected no write",
                   register_write_address, register_write_data, host_ready);
        end else begin
          e = exp_q.pop_front();
          checkOutput("write_content", {10'b0, host_ready, register_write_address, register_write_data},
                      {10'b0, e.host, e.addr, e.data});
          checkOutput("write_cycle", cyc, e.at_cyc);
        end
      end else if (host_ready) begin
        total_cnt++;
        $display("[TB] FAIL stray_host_ready: got host_ready 1 without write, expected 0");
      end
    end
  end

  initial begin
    int hi;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step(2);
    checkOutput("reset_write_en", register_write_en, 0);
    checkOutput("reset_host_ready", host_ready, 0);
    checkOutput("reset_cop_ready", cop_write_ready, 1);
    checkOutput("reset_level", cop_fifo_level, 0);
    checkOutput("reset_conflicts", conflict_count, 0);
    checkOutput("reset_protocol_error", protocol_error, 0);
    reset_n = 1'b1;
    step(4);

    // CPU write alone, strobe held high long after the ready pulse
    applyStimulus(1, 5'h05, 16'hBEEF, 0, 0, 0, 0);
    expectWrite(1, 5'h05, 16'hBEEF, cyc + 2);
    step(6);
    applyStimulus(0, 5'h05, 16'hBEEF, 0, 0, 0, 0);
    step(2);
    checkOutput("held_en_no_error", protocol_error, 0);

    // copper burst of six back-to-back writes
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 1, 5'(i + 1), 16'hA000 + 16'(i), 0);
      expectWrite(0, 5'(i + 1), 16'hA000 + 16'(i), cyc + 2);
      checkOutput("burst_cop_ready", cop_write_ready, 1);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step(4);

    // contention: fill FIFO under stall, then release one grant at a time
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 5'h08 + 5'(i), 16'hC000 + 16'(i), 1);
      step();
    end
    applyStimulus(1, 5'h10, 16'h1000, 0, 0, 0, 1);
    checkOutput("contention_level_full", cop_fifo_level, 4);
    checkOutput("contention_ready_low", cop_write_ready, 0);
    step();
    hi = 0;
    for (int r = 0; r < 5; r++) begin
      if (r == 3) expectWrite(0, 5'h08, 16'hC000, cyc + 1);
      else        expectWrite(1, 5'h10 + 5'(hi), 16'h1000 + 16'(hi), cyc + 1);
      applyStimulus(1, 5'h10 + 5'(hi), 16'h1000 + 16'(hi), 0, 0, 0, 0);
      step();
      checkOutput("conflict_count_round", conflict_count, r + 1);
      if (r == 3) begin
        applyStimulus(1, 5'h10 + 5'(hi), 16'h1000 + 16'(hi), 0, 0, 0, 1);
        step();
      end else begin
        hi++;
        applyStimulus(0, 5'h10 + 5'(hi), 16'h1000 + 16'(hi), 0, 0, 0, 1);
        step();
        if (r < 4) begin
          applyStimulus(1, 5'h10 + 5'(hi), 16'h1000 + 16'(hi), 0, 0, 0, 1);
          step();
        end
      end
    end

    // stall with both sources pending: nothing moves for five cycles
    checkOutput("stall_start_level", cop_fifo_level, 3);
    applyStimulus(1, 5'h1A, 16'h5A5A, 0, 0, 0, 1);
    step();
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_level_hold", cop_fifo_level, 3);
      step();
    end
    expectWrite(1, 5'h1A, 16'h5A5A, cyc + 1);
    expectWrite(0, 5'h09, 16'hC001, cyc + 2);
    expectWrite(0, 5'h0A, 16'hC002, cyc + 3);
    expectWrite(0, 5'h0B, 16'hC003, cyc + 4);
    applyStimulus(1, 5'h1A, 16'h5A5A, 0, 0, 0, 0);
    step();
    applyStimulus(0, 5'h1A, 16'h5A5A, 0, 0, 0, 0);
    step(5);
    checkOutput("stall_drained_level", cop_fifo_level, 0);
    checkOutput("stall_conflicts", conflict_count, 6);

    // full FIFO: pop and refused push in the same cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 5'h18 + 5'(i), 16'hF000 + 16'(i), 1);
      step();
    end
    applyStimulus(0, 0, 0, 1, 5'h1F, 16'hFFFF, 0);
    checkOutput("full_level", cop_fifo_level, 4);
    checkOutput("full_ready_low", cop_write_ready, 0);
    for (int i = 0; i < 4; i++) expectWrite(0, 5'h18 + 5'(i), 16'hF000 + 16'(i), cyc + 1 + i);
    step();
    checkOutput("full_level_after_pop", cop_fifo_level, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step(6);

    // reset while the slot is pending and the FIFO holds two entries
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 1, 5'h03 + 5'(i), 16'h3300 + 16'(i), 1);
      step();
    end
    applyStimulus(1, 5'h07, 16'h7777, 0, 0, 0, 1);
    step();
    applyStimulus(0, 5'h07, 16'h7777, 0, 0, 0, 1);
    step();
    applyStimulus(1, 5'h08, 16'h8888, 0, 0, 0, 1);
    step();
    checkOutput("protocol_error_set", protocol_error, 1);
    checkOutput("pre_reset_level", cop_fifo_level, 2);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_addr", register_write_address, 0);
    checkOutput("async_reset_data", register_write_data, 0);
    checkOutput("async_reset_level", cop_fifo_level, 0);
    checkOutput("async_reset_error", protocol_error, 0);
    checkOutput("async_reset_conflicts", conflict_count, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step(2);
    reset_n = 1'b1;
    step(8);
    checkOutput("post_reset_level", cop_fifo_level, 0);
    checkOutput("post_reset_ready", cop_write_ready, 1);
    checkOutput("post_reset_write_en", register_write_en, 0);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
